// File: rtl/spi_flash_pkg.sv
// Shared opcode constants and responder state encoding for the SPI flash
// responder, its controller and benches.
package spi_flash_pkg;

  localparam logic [7:0] OP_READ      = 8'h03;
  localparam logic [7:0] OP_FAST_READ = 8'h0B;
  localparam logic [7:0] OP_RDSR      = 8'h05;
  localparam logic [7:0] OP_RDID      = 8'h9F;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    DATA,
    IGNORE
  } state_t;

  // RDID byte sequence: three ID bytes MSB first, then zeros forever.
  function automatic logic [7:0] id_byte(input logic [23:0] id, input logic [1:0] idx);
    case (idx)
      2'd0:    id_byte = id[23:16];
      2'd1:    id_byte = id[15:8];
      2'd2:    id_byte = id[7:0];
      default: id_byte = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// 2-FF synchronizers for the asynchronous SPI pins plus edge detection on the
// synchronized sclk and cs_n samples.
module spi_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic spi_sclk,
  input  logic spi_cs_n,
  input  logic spi_mosi,
  output logic mosi_s,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_fall,
  output logic cs_rise
);

  logic [2:0] sclk_q;
  logic [2:0] cs_q;
  logic [1:0] mosi_q;

  // cs chain resets low so a cs_n already low at reset release produces no
  // fall; a transaction only starts after cs_n has been seen high.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_q <= '0;
      cs_q   <= '0;
      mosi_q <= '0;
    end else begin
      sclk_q <= {sclk_q[1:0], spi_sclk};
      cs_q   <= {cs_q[1:0], spi_cs_n};
      mosi_q <= {mosi_q[0], spi_mosi};
    end
  end

  assign mosi_s    = mosi_q[1];
  assign sclk_rise =  sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] &  sclk_q[2];
  assign cs_fall   = ~cs_q[1]   &  cs_q[2];
  assign cs_rise   =  cs_q[1]   & ~cs_q[2];

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash target emulator (READ/RDSR/RDID) backed by a 1-clk-latency
// byte memory. Define SPI_RESP_FAST_READ_EN to accept FAST_READ (0x0B).
module spi_flash_responder
  import spi_flash_pkg::*;
#(
  parameter int          ADDR_W   = 24,
  parameter logic [23:0] JEDEC_ID = 24'hEF4016,
  parameter logic [7:0]  STATUS   = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_sclk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              busy
);

  logic mosi_s, sclk_rise, sclk_fall, cs_fall, cs_rise;

  spi_edge_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .spi_sclk  (spi_sclk),
    .spi_cs_n  (spi_cs_n),
    .spi_mosi  (spi_mosi),
    .mosi_s    (mosi_s),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .cs_fall   (cs_fall),
    .cs_rise   (cs_rise)
  );

  state_t            state;
  logic [4:0]        bit_cnt;
  logic [23:0]       sh;
  logic [7:0]        op;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        tx_sr;
  logic [1:0]        id_idx;
  logic              rd_pend;

  logic [23:0] sh_next;
  assign sh_next = {sh[22:0], mosi_s};
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      sh          <= '0;
      op          <= '0;
      addr        <= '0;
      tx_sr       <= '0;
      id_idx      <= '0;
      rd_pend     <= 1'b0;
      spi_miso    <= 1'b0;
      spi_miso_oe <= 1'b0;
      mem_rd      <= 1'b0;
      mem_addr    <= '0;
    end else begin
      mem_rd  <= 1'b0;
      rd_pend <= mem_rd;
      // Memory data lands well before the next sclk fall, which shifts it out.
      if (rd_pend) tx_sr <= mem_rdata;

      if (cs_rise) begin
        state       <= IDLE;
        bit_cnt     <= '0;
        rd_pend     <= 1'b0;
        spi_miso    <= 1'b0;
        spi_miso_oe <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (cs_fall) begin
              state   <= CMD;
              // An sclk rise in the same sample as the cs fall is bit 7 of CMD.
              bit_cnt <= sclk_rise ? 5'd1 : 5'd0;
              sh      <= sclk_rise ? sh_next : '0;
            end
          end

          CMD: begin
            if (sclk_rise) begin
              sh      <= sh_next;
              bit_cnt <= bit_cnt + 5'd1;
              if (bit_cnt == 5'd7) begin
                bit_cnt <= '0;
                op      <= sh_next[7:0];
                case (sh_next[7:0])
                  OP_READ: state <= ADDR;
`ifdef SPI_RESP_FAST_READ_EN
                  OP_FAST_READ: state <= ADDR;
`endif
                  OP_RDSR: begin
                    state <= DATA;
                    tx_sr <= STATUS;
                  end
                  OP_RDID: begin
                    state  <= DATA;
                    tx_sr  <= id_byte(JEDEC_ID, 2'd0);
                    id_idx <= 2'd1;
                  end
                  default: state <= IGNORE;
                endcase
              end
            end
          end

          ADDR: begin
            if (sclk_rise) begin
              sh      <= sh_next;
              bit_cnt <= bit_cnt + 5'd1;
              if (bit_cnt == 5'd23) begin
                bit_cnt <= '0;
                if (op == OP_FAST_READ) begin
                  state <= DUMMY;
                  addr  <= sh_next[ADDR_W-1:0];
                end else begin
                  state    <= DATA;
                  mem_rd   <= 1'b1;
                  mem_addr <= sh_next[ADDR_W-1:0];
                  addr     <= sh_next[ADDR_W-1:0] + ADDR_W'(1);
                end
              end
            end
          end

          DUMMY: begin
            if (sclk_rise) begin
              bit_cnt <= bit_cnt + 5'd1;
              if (bit_cnt == 5'd7) begin
                bit_cnt  <= '0;
                state    <= DATA;
                mem_rd   <= 1'b1;
                mem_addr <= addr;
                addr     <= addr + ADDR_W'(1);
              end
            end
          end

          DATA: begin
            if (sclk_fall) begin
              spi_miso_oe <= 1'b1;
              spi_miso    <= tx_sr[7];
              tx_sr       <= {tx_sr[6:0], 1'b0};
            end
            // The rise sampling bit 0 queues the next byte (prefetch).
            if (sclk_rise) begin
              bit_cnt <= bit_cnt + 5'd1;
              if (bit_cnt[2:0] == 3'd7) begin
                bit_cnt <= '0;
                if (op == OP_RDSR) begin
                  tx_sr <= STATUS;
                end else if (op == OP_RDID) begin
                  tx_sr <= id_byte(JEDEC_ID, id_idx);
                  if (id_idx != 2'd3) id_idx <= id_idx + 2'd1;
                end else begin
                  mem_rd   <= 1'b1;
                  mem_addr <= addr;
                  addr     <= addr + ADDR_W'(1);
                end
              end
            end
          end

          IGNORE: ;

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: SPI controller model, byte memory
// model, and a scoreboard of expected MISO bytes.
module tb_spi_flash_responder;

  localparam int HALF = 6;  // sclk half period in clk cycles

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        spi_sclk = 1'b0;
  logic        spi_cs_n = 1'b1;
  logic        spi_mosi = 1'b0;
  logic        spi_miso, spi_miso_oe, mem_rd, busy;
  logic [23:0] mem_addr;
  logic [7:0]  mem_rdata;

  int tests = 0;
  int fails = 0;

  logic [7:0]  mem [int];
  logic [23:0] rd_log [$];
  logic [7:0]  exp_q [$];

  always #5 clk = ~clk;

  spi_flash_responder dut (
    .clk         (clk),
    .rst         (rst),
    .spi_sclk    (spi_sclk),
    .spi_cs_n    (spi_cs_n),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .mem_rd      (mem_rd),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .busy        (busy)
  );

  // Synchronous byte memory: data valid one clk after the read strobe.
  always @(posedge clk) begin
    if (mem_rd === 1'b1) begin
      mem_rdata <= mem.exists(int'(mem_addr)) ? mem[int'(mem_addr)] : 8'h00;
      rd_log.push_back(mem_addr);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish, expected finish within 1ms");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic half_per();
    repeat (HALF) @(negedge clk);
  endtask

  // One sclk cycle; MISO and OE are sampled as the rising edge is driven.
  task automatic clk_bit(input logic mo, output logic mi, output logic oe);
    spi_mosi = mo;
    half_per();
    spi_sclk = 1'b1;
    mi = spi_miso;
    oe = spi_miso_oe;
    half_per();
    spi_sclk = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input string tag);
    logic mi, oe;
    logic oe_any = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(b[i], mi, oe);
      oe_any |= oe;
    end
    check({tag, "_oe"}, oe_any, 1'b0);
  endtask

  task automatic recv_bytes(input int n, input string tag);
    logic mi, oe;
    for (int k = 0; k < n; k++) begin
      logic [7:0] b = 8'h00;
      logic [7:0] e;
      logic       oe_all = 1'b1;
      for (int i = 0; i < 8; i++) begin
        clk_bit(1'b0, mi, oe);
        b = {b[6:0], mi};
        oe_all &= oe;
      end
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
      check(tag, b, e);
      check({tag, "_oe"}, oe_all, 1'b1);
    end
  endtask

  task automatic cs_low();
    @(negedge clk);
    spi_cs_n = 1'b0;
    half_per();
  endtask

  task automatic cs_high(input string tag);
    half_per();
    spi_cs_n = 1'b1;
    repeat (5) @(negedge clk);
    check({tag, "_oe_off"}, spi_miso_oe, 1'b0);
    check({tag, "_busy_off"}, busy, 1'b0);
  endtask

  initial begin
    int   base;
    logic mi, oe;
    logic oe_any;

    mem[32'h10] = 8'hA5; mem[32'h11] = 8'h5A; mem[32'h12] = 8'hC3; mem[32'h13] = 8'h3C;
    mem[32'hFFFFFE] = 8'h11; mem[32'hFFFFFF] = 8'h22; mem[32'h0] = 8'h33; mem[32'h1] = 8'h44;
    mem[32'h100] = 8'h77; mem[32'h101] = 8'h88;

    repeat (4) @(negedge clk);
    check("rst_miso", spi_miso, 1'b0);
    check("rst_oe", spi_miso_oe, 1'b0);
    check("rst_mem_rd", mem_rd, 1'b0);
    check("rst_mem_addr", mem_addr, 24'h0);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;
    repeat (6) @(negedge clk);

    // RDID
    base = rd_log.size();
    exp_q.push_back(8'hEF); exp_q.push_back(8'h40); exp_q.push_back(8'h16);
    exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    cs_low();
    check("rdid_busy", busy, 1'b1);
    send_byte(8'h9F, "rdid_cmd");
    recv_bytes(5, "rdid");
    cs_high("rdid");
    check("rdid_no_rd", rd_log.size() - base, 0);

    // READ at 0x10; the bit-0 rise of the last byte prefetches 0x14 too
    base = rd_log.size();
    exp_q.push_back(8'hA5); exp_q.push_back(8'h5A); exp_q.push_back(8'hC3); exp_q.push_back(8'h3C);
    cs_low();
    send_byte(8'h03, "rd_cmd");
    send_byte(8'h00, "rd_a2"); send_byte(8'h00, "rd_a1"); send_byte(8'h10, "rd_a0");
    recv_bytes(4, "rd_data");
    cs_high("rd");
    check("rd_count", rd_log.size() - base, 5);
    for (int k = 0; k < 4; k++)
      check("rd_addr", (rd_log.size() > base + k) ? rd_log[base + k] : 24'hxxxxxx, 24'h10 + k);

    // READ across the top of the address space
    base = rd_log.size();
    exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33); exp_q.push_back(8'h44);
    cs_low();
    send_byte(8'h03, "wr_cmd");
    send_byte(8'hFF, "wr_a2"); send_byte(8'hFF, "wr_a1"); send_byte(8'hFE, "wr_a0");
    recv_bytes(4, "wrap_data");
    cs_high("wrap");
    check("wrap_count", rd_log.size() - base, 5);
    check("wrap_a0", (rd_log.size() > base + 0) ? rd_log[base + 0] : 24'hx, 24'hFFFFFE);
    check("wrap_a1", (rd_log.size() > base + 1) ? rd_log[base + 1] : 24'hx, 24'hFFFFFF);
    check("wrap_a2", (rd_log.size() > base + 2) ? rd_log[base + 2] : 24'hx, 24'h000000);
    check("wrap_a3", (rd_log.size() > base + 3) ? rd_log[base + 3] : 24'hx, 24'h000001);

    // Abort mid-address, then RDSR
    base = rd_log.size();
    cs_low();
    send_byte(8'h03, "ab_cmd");
    for (int i = 0; i < 12; i++) clk_bit(1'b0, mi, oe);
    cs_high("abort");
    check("abort_no_rd", rd_log.size() - base, 0);
    exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    cs_low();
    send_byte(8'h05, "rdsr_cmd");
    recv_bytes(2, "rdsr");
    cs_high("rdsr");

    // Unknown opcode is ignored, following READ still works
    base = rd_log.size();
    cs_low();
    send_byte(8'hAB, "ign_cmd");
    oe_any = 1'b0;
    for (int i = 0; i < 24; i++) begin clk_bit(1'b1, mi, oe); oe_any |= oe; end
    check("ign_oe", oe_any, 1'b0);
    cs_high("ign");
    check("ign_no_rd", rd_log.size() - base, 0);
    exp_q.push_back(8'hC3); exp_q.push_back(8'h3C);
    cs_low();
    send_byte(8'h03, "r2_cmd");
    send_byte(8'h00, "r2_a2"); send_byte(8'h00, "r2_a1"); send_byte(8'h12, "r2_a0");
    recv_bytes(2, "r2_data");
    cs_high("r2");
    check("r2_a0", (rd_log.size() > base) ? rd_log[base] : 24'hx, 24'h12);

    // FAST_READ
    base = rd_log.size();
    cs_low();
    send_byte(8'h0B, "fr_cmd");
    send_byte(8'h00, "fr_a2"); send_byte(8'h01, "fr_a1"); send_byte(8'h00, "fr_a0");
`ifdef SPI_RESP_FAST_READ_EN
    exp_q.push_back(8'h77); exp_q.push_back(8'h88);
    send_byte(8'hFF, "fr_dummy");
    recv_bytes(2, "fr_data");
    cs_high("fr");
    check("fr_a0", (rd_log.size() > base) ? rd_log[base] : 24'hx, 24'h100);
`else
    send_byte(8'h00, "fr_ign0");
    send_byte(8'h00, "fr_ign1");
    cs_high("fr");
    check("fr_no_rd", rd_log.size() - base, 0);
`endif

    // Reset mid-transaction: cs_n held low afterwards must be ignored
    cs_low();
    send_byte(8'h03, "rr_cmd");
    for (int i = 0; i < 10; i++) clk_bit(1'b0, mi, oe);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rr_busy_rst", busy, 1'b0);
    rst = 1'b0;
    base = rd_log.size();
    send_byte(8'h03, "rr_post0");
    send_byte(8'h00, "rr_post1");
    check("rr_busy_post", busy, 1'b0);
    cs_high("rr");
    check("rr_no_rd", rd_log.size() - base, 0);

    // cs_n fall and first sclk rise land in the same synchronizer sample
    exp_q.push_back(8'hEF);
    @(negedge clk);
    spi_mosi = 1'b1;
    @(negedge clk);
    spi_cs_n = 1'b0;
    spi_sclk = 1'b1;
    half_per();
    spi_sclk = 1'b0;
    for (int i = 6; i >= 0; i--) begin
      logic [7:0] op = 8'h9F;
      clk_bit(op[i], mi, oe);
    end
    recv_bytes(1, "same_edge");
    cs_high("same_edge");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
